// File: rtl/kyber_pkg.sv
// +-----------------------------------------------------------------------+
// | kyber_pkg: ML-KEM constants and helpers shared by the codec datapath  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    // 19 bits is the worst-case fill (D-1 leftover bits plus one new byte).
    localparam int ACC_W = 20;
    localparam int CNT_W = 5;

    function automatic int bytes_per_poly(input int d);
        return 32 * d;
    endfunction

endpackage : kyber_pkg

`default_nettype wire

// File: rtl/byte_decode_if.sv
// +-----------------------------------------------------------------------+
// | byte_decode_if: byte-in / coefficient-out valid-ready bundle          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface byte_decode_if #(
    parameter int D = 10
);

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] out_data;
    logic [7:0]   out_index;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_index, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_index, out_last, out_valid
    );

endinterface : byte_decode_if

`default_nettype wire

// File: rtl/cond_sub_q.sv
// +-----------------------------------------------------------------------+
// | cond_sub_q: 12-bit conditional subtraction of q (3329)                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cond_sub_q
    import kyber_pkg::*;
(
    input  wire logic [11:0] val_i,
    output logic      [11:0] val_o
);

    localparam logic [11:0] c_Q = 12'(KYBER_Q);

    assign val_o = (val_i >= c_Q) ? (val_i - c_Q) : val_i;

endmodule : cond_sub_q

`default_nettype wire

// File: rtl/byte_decode.sv
// +-----------------------------------------------------------------------+
// | byte_decode: little-endian byte stream -> D-bit coefficients          |
// | Option BYTE_DECODE_MODQ_EN: reduce mod q when D == 12. Rev 1.0        |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module byte_decode
    import kyber_pkg::*;
#(
    parameter int D = 10
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   clear,
    byte_decode_if.slave bus
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic emit;

    // Load and emit are mutually exclusive by construction of the fill level.
    assign in_ready  = (cnt_q < CNT_W'(D));
    assign out_valid = ~in_ready;
    assign accept    = bus.in_valid & in_ready;
    assign emit      = out_valid & bus.out_ready;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            idx_d = '0;
        end else if (accept) begin
            acc_d = acc_q | (ACC_W'(bus.in_data) << cnt_q);
            cnt_d = cnt_q + CNT_W'(8);
        end else if (emit) begin
            acc_d = acc_q >> D;
            cnt_d = cnt_q - CNT_W'(D);
            idx_d = idx_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_index = idx_q;
    assign bus.out_last  = (idx_q == 8'd255);

`ifdef BYTE_DECODE_MODQ_EN
    generate
        if (D == 12) begin : g_modq
            logic [11:0] w_reduced;

            cond_sub_q u_cond_sub_q (
                .val_i (acc_q[11:0]),
                .val_o (w_reduced)
            );

            assign bus.out_data = w_reduced;
        end else begin : g_raw
            assign bus.out_data = acc_q[D-1:0];
        end
    endgenerate
`else
    assign bus.out_data = acc_q[D-1:0];
`endif

endmodule : byte_decode

`default_nettype wire

// File: tb/tb_byte_decode.sv
// +-----------------------------------------------------------------------+
// | tb_byte_decode: directed + random-stall bench, four D configurations  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_byte_decode;

    localparam int NI = 4; // 0: D=10, 1: D=4, 2: D=1, 3: D=12

    logic clk;
    logic rst_n;
    logic clear;

    logic [7:0]  r_in_data   [NI];
    logic        r_in_valid  [NI];
    logic        r_out_ready [NI];
    logic        w_in_ready  [NI];
    logic        w_out_valid [NI];
    logic [11:0] w_out_data  [NI];
    logic [7:0]  w_out_index [NI];
    logic        w_out_last  [NI];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    byte_decode_if #(.D(10)) bus10 ();
    byte_decode_if #(.D(4))  bus4  ();
    byte_decode_if #(.D(1))  bus1  ();
    byte_decode_if #(.D(12)) bus12 ();

    byte_decode #(.D(10)) u_d10 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus10));
    byte_decode #(.D(4))  u_d4  (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus4));
    byte_decode #(.D(1))  u_d1  (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1));
    byte_decode #(.D(12)) u_d12 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus12));

    assign bus10.in_data = r_in_data[0];  assign bus10.in_valid = r_in_valid[0];
    assign bus10.out_ready = r_out_ready[0];
    assign bus4.in_data  = r_in_data[1];  assign bus4.in_valid  = r_in_valid[1];
    assign bus4.out_ready  = r_out_ready[1];
    assign bus1.in_data  = r_in_data[2];  assign bus1.in_valid  = r_in_valid[2];
    assign bus1.out_ready  = r_out_ready[2];
    assign bus12.in_data = r_in_data[3];  assign bus12.in_valid = r_in_valid[3];
    assign bus12.out_ready = r_out_ready[3];

    assign w_in_ready[0] = bus10.in_ready;  assign w_out_valid[0] = bus10.out_valid;
    assign w_out_data[0] = 12'(bus10.out_data);
    assign w_out_index[0] = bus10.out_index; assign w_out_last[0] = bus10.out_last;
    assign w_in_ready[1] = bus4.in_ready;   assign w_out_valid[1] = bus4.out_valid;
    assign w_out_data[1] = 12'(bus4.out_data);
    assign w_out_index[1] = bus4.out_index;  assign w_out_last[1] = bus4.out_last;
    assign w_in_ready[2] = bus1.in_ready;   assign w_out_valid[2] = bus1.out_valid;
    assign w_out_data[2] = 12'(bus1.out_data);
    assign w_out_index[2] = bus1.out_index;  assign w_out_last[2] = bus1.out_last;
    assign w_in_ready[3] = bus12.in_ready;  assign w_out_valid[3] = bus12.out_valid;
    assign w_out_data[3] = 12'(bus12.out_data);
    assign w_out_index[3] = bus12.out_index; assign w_out_last[3] = bus12.out_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        $display("FAIL %s: timed out waiting for handshake", tag);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int sel, input logic [7:0] b);
        int n;
        n = 0;
        r_in_data[sel]  = b;
        r_in_valid[sel] = 1'b1;
        while (!w_in_ready[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!w_in_ready[sel]) timeout_fail($sformatf("push%0d", sel));
        @(negedge clk);
        r_in_valid[sel] = 1'b0;
    endtask

    task automatic pop(input int sel, input string tag, input logic [11:0] ed,
                       input logic [7:0] ei, input logic el);
        int n;
        n = 0;
        r_out_ready[sel] = 1'b1;
        while (!w_out_valid[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!w_out_valid[sel]) begin
            timeout_fail(tag);
        end else begin
            chk({tag, "_data"},  w_out_data[sel],  ed);
            chk({tag, "_index"}, w_out_index[sel], ei);
            chk({tag, "_last"},  w_out_last[sel],  el);
        end
        @(negedge clk);
        r_out_ready[sel] = 1'b0;
    endtask

    logic [7:0]    rnd_bytes [320];
    logic [2559:0] rnd_stream;
    logic [11:0]   mq_exp;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < NI; i++) begin
            r_in_data[i]   = 8'h00;
            r_in_valid[i]  = 1'b0;
            r_out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  w_in_ready[0],  1);
        chk("rst_out_valid", w_out_valid[0], 0);
        chk("rst_out_data",  w_out_data[0],  0);
        chk("rst_out_index", w_out_index[0], 0);
        chk("rst_out_last",  w_out_last[0],  0);
        rst_n = 1'b1;
        @(negedge clk);

        // D=10 latency: coefficient only after the second byte lands.
        push(0, 8'h7C);
        chk("d10_lat_valid_1byte", w_out_valid[0], 0);
        push(0, 8'h00);
        chk("d10_lat_valid_2byte", w_out_valid[0], 1);
        pop(0, "d10_c0", 12'd124, 8'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            push(0, 8'h00);
            pop(0, $sformatf("d10_c%0d", k), 12'd0, 8'(k), 1'b0);
        end

        push(0, 8'hFF);
        push(0, 8'h03);
        pop(0, "d10_max", 12'd1023, 8'd4, 1'b0);
        for (int k = 5; k <= 7; k++) begin
            push(0, 8'h00);
            pop(0, $sformatf("d10_z%0d", k), 12'd0, 8'(k), 1'b0);
        end

        push(1, 8'hA5);
        chk("d4_in_ready_full", w_in_ready[1], 0);
        pop(1, "d4_lo", 12'd5,  8'd0, 1'b0);
        pop(1, "d4_hi", 12'd10, 8'd1, 1'b0);

        push(2, 8'h01);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("d1_in_ready_emit%0d", k), w_in_ready[2], 0);
            pop(2, $sformatf("d1_b%0d", k), (k == 0) ? 12'd1 : 12'd0, 8'(k), 1'b0);
        end
        chk("d1_in_ready_drained", w_in_ready[2], 1);

`ifdef BYTE_DECODE_MODQ_EN
        mq_exp = 12'd766;
`else
        mq_exp = 12'd4095;
`endif
        push(3, 8'hFF);
        push(3, 8'hFF);
        pop(3, "d12_c0", mq_exp, 8'd0, 1'b0);
        push(3, 8'hFF);
        pop(3, "d12_c1", mq_exp, 8'd1, 1'b0);

        // Asynchronous reset mid-polynomial: outputs drop without a clock edge.
        push(0, 8'h12);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  w_in_ready[0],  1);
        chk("arst_out_valid", w_out_valid[0], 0);
        chk("arst_out_data",  w_out_data[0],  0);
        chk("arst_out_index", w_out_index[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(0, 8'h7C);
        push(0, 8'h00);
        pop(0, "arst_c0", 12'd124, 8'd0, 1'b0);

        push(0, 8'hAB);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_in_ready",  w_in_ready[0],  1);
        chk("clr_out_valid", w_out_valid[0], 0);
        chk("clr_out_index", w_out_index[0], 0);
        push(0, 8'h7C);
        push(0, 8'h00);
        pop(0, "clr_c0", 12'd124, 8'd0, 1'b0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Full D=10 polynomial with random gaps and stalls against a bit-slice model.
        for (int i = 0; i < 320; i++) begin
            rnd_bytes[i] = 8'($urandom);
            rnd_stream[8*i +: 8] = rnd_bytes[i];
        end
        fork
            begin
                for (int i = 0; i < 320; i++) begin
                    if ($urandom_range(3) == 0) @(negedge clk);
                    push(0, rnd_bytes[i]);
                end
            end
            begin
                int got;
                int n;
                got = 0;
                n   = 0;
                while (got < 256 && n < 5000) begin
                    r_out_ready[0] = ($urandom_range(2) != 0);
                    if (w_out_valid[0] && r_out_ready[0]) begin
                        chk($sformatf("rnd_c%0d", got),
                            {11'd0, w_out_last[0], w_out_index[0], w_out_data[0]},
                            {11'd0, (got == 255), 8'(got), 2'b00, rnd_stream[10*got +: 10]});
                        got++;
                    end
                    @(negedge clk);
                    n++;
                end
                r_out_ready[0] = 1'b0;
                if (got < 256) timeout_fail("rnd_outputs");
            end
        join

        r_out_ready[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("rnd_no_extra_valid", w_out_valid[0], 0);
        chk("rnd_cnt_empty",      u_d10.cnt_q,    0);
        chk("rnd_in_ready",       w_in_ready[0],  1);
        chk("rnd_index_wrapped",  w_out_index[0], 0);
        r_out_ready[0] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_byte_decode

`default_nettype wire
